seg_scan_meter: RTL and testbench

- Parametrised successor to the seven-segment stream meter.
- Measures a sampled serial bit stream over a fixed window: rising-edge count (frequency), high-bit count (duty), and per-period high/low time via a sequential divider.
- Shows the selected quantity in hex on a DIGITS-wide multiplexed display driven through a 74HC595-style serial chain (ds/shclk/stclk).
- Adds over the previous block: reset, debounced mode/freeze keys, configurable shift rate, divide-by-zero handling and leading-zero blanking.

---
 rtl/seg_scan_meter_if.sv | 16 +
 rtl/seg_scan_meter.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_seg_scan_meter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_meter_if.sv
// Bundle of the meter's sample/key inputs and serial display outputs.
// The slave modport is the meter side; the master modport drives the samples and keys.
interface seg_scan_meter_if #(
  parameter int unsigned SAMPLE_W = 32
);
  logic [SAMPLE_W-1:0] dsq;
  logic                key0;
  logic                key1;
  logic                ds;
  logic                shclk;
  logic                stclk;
  logic [1:0]          mode;

  modport master (output dsq, key0, key1, input ds, shclk, stclk, mode);
  modport slave  (input dsq, key0, key1, output ds, shclk, stclk, mode);
endinterface

// File: rtl/seg_scan_meter.sv
// Serial bit-stream meter: windowed edge/high counts, per-period high/low time by
// sequential division, and a multiplexed hex display shifted out to a 595-style chain.
module seg_scan_meter #(
  parameter int unsigned SAMPLE_W = 32,
  parameter int unsigned WINDOW   = 31250000,
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned DEBOUNCE = 200000,
  parameter bit          LZB      = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  seg_scan_meter_if.slave bus
);
  localparam logic [63:0] TotalBits = 64'(WINDOW) * 64'(SAMPLE_W);
  localparam logic [2:0]  LastDigit = 3'(DIGITS - 1);

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    case (n)
      4'h0: return 8'h03;  4'h1: return 8'h9F;  4'h2: return 8'h25;  4'h3: return 8'h0D;
      4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1F;
      4'h8: return 8'h01;  4'h9: return 8'h09;  4'hA: return 8'h11;  4'hB: return 8'hC1;
      4'hC: return 8'h63;  4'hD: return 8'h85;  4'hE: return 8'h61;  default: return 8'h71;
    endcase
  endfunction

  // Measurement window
  logic        prev_q;
  logic [31:0] wcnt_q, fcnt_q, hcnt_q, freq_q, duty_q;
  logic [31:0] ce, c1;
  logic        win_end;

  always_comb begin
    ce = 32'(~prev_q & bus.dsq[0]);
    c1 = 32'(bus.dsq[0]);
    for (int i = 0; i < int'(SAMPLE_W) - 1; i++) begin
      ce = ce + 32'(~bus.dsq[i] & bus.dsq[i+1]);
      c1 = c1 + 32'(bus.dsq[i+1]);
    end
  end

  assign win_end = (wcnt_q == WINDOW - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      wcnt_q <= '0;
      fcnt_q <= '0;
      hcnt_q <= '0;
      freq_q <= '0;
      duty_q <= '0;
    end else begin
      prev_q <= bus.dsq[SAMPLE_W-1];
      if (win_end) begin
        wcnt_q <= '0;
        fcnt_q <= '0;
        hcnt_q <= '0;
        freq_q <= sat_add(fcnt_q, ce);
        duty_q <= sat_add(hcnt_q, c1);
      end else begin
        wcnt_q <= wcnt_q + 32'd1;
        fcnt_q <= sat_add(fcnt_q, ce);
        hcnt_q <= sat_add(hcnt_q, c1);
      end
    end
  end

  // Restoring divider: load, 32 steps for t1, load, 32 steps for t0 (66 clk total)
  typedef enum logic [2:0] {DvIdle, DvLoad1, DvRun1, DvLoad2, DvRun2} div_st_e;
  div_st_e     dv_q, dv_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, tmp_q, tmp_d, t1_q, t1_d, t0_q, t0_d;
  logic [4:0]  step_q, step_d;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_nx, quo_nx, t0_num;

  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    rem_ge = (rem_sh >= {1'b0, freq_q});
    rem_nx = rem_ge ? 32'(rem_sh - {1'b0, freq_q}) : rem_sh[31:0];
    quo_nx = {quo_q[30:0], rem_ge};
    t0_num = 32'(TotalBits - {32'd0, duty_q});
    dv_d   = dv_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    step_d = step_q;
    tmp_d  = tmp_q;
    t1_d   = t1_q;
    t0_d   = t0_q;
    case (dv_q)
      DvIdle: ;
      DvLoad1, DvLoad2: begin
        rem_d  = '0;
        quo_d  = (dv_q == DvLoad1) ? duty_q : t0_num;
        step_d = '0;
        dv_d   = (dv_q == DvLoad1) ? DvRun1 : DvRun2;
      end
      DvRun1, DvRun2: begin
        rem_d  = rem_nx;
        quo_d  = quo_nx;
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) begin
          if (dv_q == DvRun1) begin
            tmp_d = quo_nx;
            dv_d  = DvLoad2;
          end else begin
            // A zero divisor yields all-ones quotients; report 0 instead
            t1_d = (freq_q == '0) ? '0 : tmp_q;
            t0_d = (freq_q == '0) ? '0 : quo_nx;
            dv_d = DvIdle;
          end
        end
      end
      default: dv_d = DvIdle;
    endcase
    if (win_end) dv_d = DvLoad1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q   <= DvIdle;
      rem_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      tmp_q  <= '0;
      t1_q   <= '0;
      t0_q   <= '0;
    end else begin
      dv_q   <= dv_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      step_q <= step_d;
      tmp_q  <= tmp_d;
      t1_q   <= t1_d;
      t0_q   <= t0_d;
    end
  end

  // Key synchronisers, debounce filters, mode/freeze and displayed value
  logic [1:0]  k_s1_q, k_s2_q, filt_q, key_fall;
  logic [31:0] kcnt_q [2];
  logic [1:0]  mode_q;
  logic        freeze_q, resample_q;
  logic [31:0] disp_q, sel_val;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      key_fall[k] = filt_q[k] & ~k_s2_q[k] & (kcnt_q[k] == DEBOUNCE - 1);
    end
    case (mode_q)
      2'd0:    sel_val = freq_q;
      2'd1:    sel_val = duty_q;
      2'd2:    sel_val = t1_q;
      default: sel_val = t0_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_s1_q     <= '0;
      k_s2_q     <= '0;
      filt_q     <= '0;
      for (int k = 0; k < 2; k++) kcnt_q[k] <= '0;
      mode_q     <= '0;
      freeze_q   <= 1'b0;
      resample_q <= 1'b0;
      disp_q     <= '0;
    end else begin
      k_s1_q <= {bus.key1, bus.key0};
      k_s2_q <= k_s1_q;
      for (int k = 0; k < 2; k++) begin
        if (k_s2_q[k] == filt_q[k]) begin
          kcnt_q[k] <= '0;
        end else if (kcnt_q[k] == DEBOUNCE - 1) begin
          filt_q[k] <= k_s2_q[k];
          kcnt_q[k] <= '0;
        end else begin
          kcnt_q[k] <= kcnt_q[k] + 32'd1;
        end
      end
      if (key_fall[0]) mode_q <= mode_q + 2'd1;
      if (key_fall[1]) freeze_q <= ~freeze_q;
      // Sample one cycle after a mode step so the new mode's value is taken
      resample_q <= key_fall[0];
      if (!freeze_q || resample_q) disp_q <= sel_val;
    end
  end

  // Serial scan: two ticks per bit, then a two-tick latch pulse per digit
  typedef enum logic [1:0] {ScBitA, ScBitB, ScLatch1, ScLatch2} scan_st_e;
  scan_st_e    sc_q, sc_d;
  logic [31:0] tick_cnt_q;
  logic        tick, upper_zero, ds_q, ds_d, shclk_q, shclk_d, stclk_q, stclk_d;
  logic [3:0]  bit_q, bit_d;
  logic [2:0]  digit_q, digit_d;
  logic [15:0] frame_q, frame_d, frame_new;
  logic [7:0]  seg;

  assign tick = (tick_cnt_q == CLK_DIV - 1);

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(digit_q) && i < int'(DIGITS) && disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    seg = seg_lut(disp_q[{digit_q, 2'b00} +: 4]);
    if (LZB && digit_q != 3'd0 && upper_zero) seg = 8'hFF;
    frame_new = {8'h80 >> digit_q, seg};
  end

  always_comb begin
    sc_d    = sc_q;
    bit_d   = bit_q;
    digit_d = digit_q;
    frame_d = frame_q;
    ds_d    = ds_q;
    shclk_d = shclk_q;
    stclk_d = stclk_q;
    if (tick) begin
      case (sc_q)
        ScBitA: begin
          stclk_d = 1'b0;
          shclk_d = 1'b0;
          if (bit_q == 4'd0) begin
            frame_d = frame_new;
            ds_d    = frame_new[0];
          end else begin
            ds_d = frame_q[bit_q];
          end
          sc_d = ScBitB;
        end
        ScBitB: begin
          shclk_d = 1'b1;
          if (bit_q == 4'd15) begin
            sc_d = ScLatch1;
          end else begin
            bit_d = bit_q + 4'd1;
            sc_d  = ScBitA;
          end
        end
        ScLatch1: begin
          shclk_d = 1'b0;
          stclk_d = 1'b1;
          sc_d    = ScLatch2;
        end
        default: begin
          stclk_d = 1'b1;
          bit_d   = 4'd0;
          digit_d = (digit_q == LastDigit) ? 3'd0 : digit_q + 3'd1;
          sc_d    = ScBitA;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      sc_q       <= ScBitA;
      bit_q      <= '0;
      digit_q    <= '0;
      frame_q    <= '0;
      ds_q       <= 1'b0;
      shclk_q    <= 1'b0;
      stclk_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 32'd1;
      sc_q       <= sc_d;
      bit_q      <= bit_d;
      digit_q    <= digit_d;
      frame_q    <= frame_d;
      ds_q       <= ds_d;
      shclk_q    <= shclk_d;
      stclk_q    <= stclk_d;
    end
  end

  assign bus.ds    = ds_q;
  assign bus.shclk = shclk_q;
  assign bus.stclk = stclk_q;
  assign bus.mode  = mode_q;
endmodule

// File: tb/tb_seg_scan_meter.sv
// Bench for seg_scan_meter: directed and random sample streams against a bit-sequence model,
// key debounce/mode/freeze sequences, decoded serial display frames and async reset.
module tb_seg_scan_meter;
  localparam int SW   = 8;
  localparam int WIN  = 100;
  localparam int DIG  = 8;
  localparam int CDIV = 1;
  localparam int DEB  = 4;
  localparam bit LZ   = 1'b1;
  localparam logic [7:0] SEG_TAB [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41,
      8'h1F, 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg_scan_meter_if #(.SAMPLE_W(SW)) bus ();

  seg_scan_meter #(
    .SAMPLE_W(SW), .WINDOW(WIN), .DIGITS(DIG), .CLK_DIV(CDIV), .DEBOUNCE(DEB), .LZB(LZ)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int                 cyc = 0;
  int                 m_wcnt = 0;
  logic               m_prev = 1'b0;
  longint unsigned    m_f = 0, m_h = 0;
  logic [31:0]        exp_freq = 0, exp_duty = 0, exp_t1 = 0, exp_t0 = 0;
  logic [31:0]        pend_t1 = 0, pend_t0 = 0;
  int                 due = -100;
  bit                 win_done = 0;
  logic [1:0]         exp_mode = 0;
  bit                 dmode = 0;
  logic [SW-1:0]      dconst = '0;

  // Display monitor: one entry per latch pulse = {shift count, assembled frame}
  logic [15:0] mon_word = '0;
  int          mon_nb = 0;
  logic        mon_sh_p = 1'b0, mon_st_p = 1'b0;
  logic [31:0] frames [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_nb   <= 0;
      mon_word <= '0;
      mon_sh_p <= 1'b0;
      mon_st_p <= 1'b0;
    end else begin
      if (bus.stclk && !mon_st_p) begin
        frames.push_back({16'(mon_nb), mon_word});
        mon_nb   <= 0;
        mon_word <= '0;
      end else if (bus.shclk && !mon_sh_p) begin
        if (mon_nb < 16) mon_word <= mon_word | (16'(bus.ds) << mon_nb);
        mon_nb <= mon_nb + 1;
      end
      mon_sh_p <= bus.shclk;
      mon_st_p <= bus.stclk;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model_frame(input logic [31:0] v, input int d);
    int          top;
    logic [7:0]  sg;
    logic [15:0] sel;
    top = 0;
    for (int i = 0; i < DIG; i++) if (((v >> (4 * i)) & 32'hF) != 0) top = i;
    sg = SEG_TAB[(v >> (4 * d)) & 32'hF];
    if (LZ && d > top) sg = 8'hFF;
    sel = 16'h8000 >> d;
    return {sel[15:8], sg};
  endfunction

  task automatic model_reset();
    m_wcnt = 0; m_prev = 1'b0; m_f = 0; m_h = 0;
    exp_freq = 0; exp_duty = 0; exp_t1 = 0; exp_t0 = 0;
    due = -100; win_done = 0; exp_mode = 0;
  endtask

  task automatic step(input int n);
    int            ce, c1;
    logic          p;
    logic [SW-1:0] w;
    longint unsigned num;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      w = bus.dsq;
      p = m_prev;
      ce = 0; c1 = 0;
      // Treat the word as consecutive stream bits, oldest first
      for (int i = 0; i < SW; i++) begin
        if (!p && w[i]) ce++;
        if (w[i]) c1++;
        p = w[i];
      end
      m_prev = w[SW-1];
      m_f = m_f + ce; if (m_f > 64'hFFFF_FFFF) m_f = 64'hFFFF_FFFF;
      m_h = m_h + c1; if (m_h > 64'hFFFF_FFFF) m_h = 64'hFFFF_FFFF;
      cyc++;
      m_wcnt++;
      if (m_wcnt == WIN) begin
        exp_freq = 32'(m_f);
        exp_duty = 32'(m_h);
        m_f = 0; m_h = 0; m_wcnt = 0;
        win_done = 1;
        num = 64'(32'(longint'(WIN) * SW - exp_duty));
        pend_t1 = (exp_freq == 0) ? 32'd0 : exp_duty / exp_freq;
        pend_t0 = (exp_freq == 0) ? 32'd0 : 32'(num / exp_freq);
        due = cyc + 66;
      end
      #1;
      if (win_done) begin
        chk("freq_at_window_end", dut.freq_q, exp_freq);
        chk("duty_at_window_end", dut.duty_q, exp_duty);
        win_done = 0;
      end
      if (m_wcnt == WIN - 1) chk("freq_held_before_end", dut.freq_q, exp_freq);
      if (cyc == due - 1) chk("t1_held_before_update", dut.t1_q, exp_t1);
      if (cyc == due) begin
        exp_t1 = pend_t1;
        exp_t0 = pend_t0;
        chk("t1_update", dut.t1_q, exp_t1);
        chk("t0_update", dut.t0_q, exp_t0);
      end
      bus.dsq = dmode ? SW'($urandom()) : dconst;
    end
  endtask

  task automatic key_level(input int which, input logic lvl, input int n);
    if (which == 0) bus.key0 = lvl; else bus.key1 = lvl;
    step(n);
  endtask

  task automatic press(input int which);
    key_level(which, 1'b0, 1); key_level(which, 1'b1, 1); key_level(which, 1'b0, 1);
    key_level(which, 1'b0, 10);
    key_level(which, 1'b1, 1); key_level(which, 1'b0, 1); key_level(which, 1'b1, 1);
    key_level(which, 1'b1, 10);
    if (which == 0) exp_mode = exp_mode + 2'd1;
    chk("mode_after_press", bus.mode, exp_mode);
  endtask

  task automatic check_display(input string tag, input logic [31:0] val);
    int start, anchor;
    start = frames.size();
    step(560);
    anchor = -1;
    for (int i = start; i < frames.size(); i++) begin
      if (anchor < 0 && frames[i][15:8] == 8'h80) anchor = i;
    end
    chk({tag, "_digit0_found"}, 64'(anchor >= 0 && anchor + DIG <= frames.size()), 64'd1);
    if (anchor >= 0 && anchor + DIG <= frames.size()) begin
      for (int d = 0; d < DIG; d++) begin
        chk($sformatf("%s_digit%0d_frame", tag, d), frames[anchor + d],
            {16'd16, model_frame(val, d)});
      end
    end
  endtask

  initial begin
    bus.dsq = '0; bus.key0 = 1'b1; bus.key1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ds", bus.ds, 0);
    chk("reset_shclk", bus.shclk, 0);
    chk("reset_stclk", bus.stclk, 0);
    chk("reset_mode", bus.mode, 0);
    repeat (3) @(posedge clk);
    model_reset();
    dconst = 8'h0F; bus.dsq = dconst;
    @(negedge clk) rst_n = 1'b1;

    step(270);
    chk("freq_0F", dut.freq_q, 100);
    chk("duty_0F", dut.duty_q, 400);
    chk("t1_0F", dut.t1_q, 4);
    chk("t0_0F", dut.t0_q, 4);

    dconst = 8'h55;
    step(200);
    chk("freq_55", dut.freq_q, 400);
    chk("t1_55", dut.t1_q, 1);
    chk("t0_55", dut.t0_q, 1);

    dconst = 8'h00;
    step(200);
    chk("freq_zero", dut.freq_q, 0);
    chk("t1_zero_known", 64'($isunknown({dut.t1_q, dut.t0_q})), 0);
    chk("t0_zero", dut.t0_q, 0);

    dmode = 1;
    step(300);

    dmode = 0; dconst = 8'h0F;
    key_level(0, 1'b0, 2); key_level(0, 1'b1, 10);
    key_level(0, 1'b0, 2); key_level(0, 1'b1, 10);
    chk("mode_short_pulses", bus.mode, 0);
    repeat (5) press(0);
    check_display("duty400", 32'd400);

    press(1);
    dconst = 8'h03;
    step(250);
    check_display("frozen", 32'd400);
    press(0);
    dconst = 8'h0F;
    step(250);
    check_display("frozen_resampled", 32'd2);
    press(1);
    step(50);
    check_display("unfrozen_t1", 32'd4);

    step(37);
    chk("mode_before_reset", bus.mode, exp_mode);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ds", bus.ds, 0);
    chk("async_reset_shclk", bus.shclk, 0);
    chk("async_reset_stclk", bus.stclk, 0);
    chk("async_reset_mode", bus.mode, 0);
    repeat (3) @(posedge clk);
    model_reset();
    dmode = 1;
    @(negedge clk) rst_n = 1'b1;
    step(250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
